load_store_unit: RTL and testbench
==================================

LOAD_STORE_UNIT -- requirements
Module: lsu

Interface
- REQ-001: Parameter DMEM_BYTES, default 2048; data memory size in bytes, power of two, multiple of 4.
- REQ-002: Parameter SW_SYNC_STAGES, default 2; number of flops in the switch-input synchronizer, at least 2.
- REQ-003: i_clk, input, 1; the single clock. All state updates on the rising edge.
- REQ-004: i_reset, input, 1; synchronous, active-high reset.
- REQ-005: i_lsu_addr, input, 32; byte address, taken from the ALU result.
- REQ-006: i_st_data, input, 32; store data, taken from rs2.
- REQ-007: i_lsu_wren, input, 1; store request, driven by the control unit's mem_wren.
- REQ-008: i_funct3, input, 3; access size and sign (instruction[14:12]).
- REQ-009: i_io_sw, input, 32; asynchronous board switch inputs.
- REQ-010: o_ld_data, output, 32; load result, already extended, routed to writeback select 2'b11.
- REQ-011: o_misalign, output, 1; the current access is misaligned or uses an illegal size.
- REQ-012: o_io_ledr, output, 32; red LED register.
- REQ-013: o_io_ledg, output, 32; green LED register.
- REQ-014: o_io_hex_lo, output, 32; HEX3..HEX0 register, one byte per digit.
- REQ-015: o_io_hex_hi, output, 32; HEX7..HEX4 register, one byte per digit.

Function
- REQ-016: Address decoding SHALL use the following map, with every other address unmapped:
  - 0x0000_0000 to DMEM_BYTES-1: DMEM.
  - 0x1000_0xxx: LEDR.
  - 0x1000_1xxx: LEDG.
  - 0x1000_2xxx: HEX_LO.
  - 0x1000_3xxx: HEX_HI.
  - 0x1001_0xxx: SW, read-only.
- REQ-017: DMEM SHALL be organised as DMEM_BYTES/4 words of 32 bits, indexed by addr[log2(DMEM_BYTES)-1:2].
- REQ-018: Reads SHALL be combinational: o_ld_data reflects the addressed location in the same cycle, giving the single-cycle datapath zero-latency loads.
- REQ-019: Writes SHALL take effect only at the rising edge of i_clk, when i_lsu_wren=1 and o_misalign=0.
- REQ-020: Store sizes by i_funct3:
  - 000 (SB): writes one byte lane, selected by addr[1:0].
  - 001 (SH): writes two lanes, selected by addr[1].
  - 010 (SW): writes all four lanes.
  - Lanes not selected SHALL retain their previous value.
- REQ-021: Store data SHALL be taken from the low bits of i_st_data and shifted into the addressed lane(s).
- REQ-022: Load sizes by i_funct3: 000 LB, 001 LH, 010 LW, 100 LBU, 101 LHU.
  - The selected byte or half SHALL be shifted down to bit 0.
  - LB and LH SHALL sign-extend; LBU and LHU SHALL zero-extend.
- REQ-023: o_misalign SHALL be 1 when any of the following holds; otherwise 0:
  - halfword access with addr[0]=1;
  - word access with addr[1:0]≠00;
  - i_lsu_wren=1 with i_funct3[2]=1 or i_funct3=011;
  - i_lsu_wren=0 with i_funct3 ∈ {011,110,111}.
- REQ-024: When o_misalign=1, o_ld_data SHALL be 0 and no state SHALL change.
- REQ-025: IO register accesses SHALL follow the same byte-lane, extension and alignment rules as DMEM; addr[11:0] SHALL select the lanes only (the register is mirrored across its 4 KiB window).
- REQ-026: Reads of SW SHALL return the output of the SW_SYNC_STAGES-flop synchronizer; i_io_sw therefore appears on loads after SW_SYNC_STAGES rising edges.
- REQ-027: Stores to SW or to any unmapped address SHALL be ignored; loads from unmapped addresses SHALL return 0.
- REQ-028: o_io_* outputs SHALL be driven directly from their registers (no combinational path from the inputs).
- REQ-029: A load from an address stored to in the previous cycle SHALL return the newly written data (write-then-read across the edge).
- REQ-030: i_lsu_wren=0 SHALL never modify any state, whatever the address or i_funct3.

Reset
- REQ-031: While i_reset=1 at a rising edge:
  - LEDR, LEDG, HEX_LO and HEX_HI SHALL become 0x0000_0000;
  - all synchronizer flops SHALL become 0;
  - stores SHALL be blocked.
- REQ-032: DMEM contents SHALL NOT be cleared by reset.
- REQ-033: o_ld_data and o_misalign remain combinational during reset and SHALL reflect the current inputs and current state.
- REQ-034: A store presented in the same cycle that reset is asserted SHALL be dropped.

Verification
- REQ-035: SW 0xDEADBEEF at 0x0000_0010, then LB/LBU at 0x13 -> 0xFFFFFFDE / 0x000000DE; LH at 0x12 -> 0xFFFFDEAD; LHU at 0x10 -> 0x0000BEEF.
- REQ-036: SW 0x11223344 at 0x20, then SB 0xAA at 0x21 and SH 0x5566 at 0x22 -> LW 0x20 returns 0x5566AA44.
- REQ-037: SW at 0x0000_0006 and LH at 0x0000_0003 -> o_misalign=1, o_ld_data=0, DMEM word at 0x4 unchanged.
- REQ-038: SW 0x000000FF to 0x1000_0000, SB 0x0F to 0x1000_1002, then assert i_reset for one edge -> LEDR first reads 0xFF and LEDG 0x000F0000; after the reset edge both read 0.
- REQ-039: Step i_io_sw from 0 to 0x00000155 -> LW 0x1001_0000 returns 0 for the first SW_SYNC_STAGES-1 edges and 0x00000155 after SW_SYNC_STAGES edges; a store to 0x1001_0000 has no effect.
- REQ-040: LW 0x2000_0000 -> 0; SW 0x12345678 to 0x2000_0000 -> no register or DMEM word changes.

Source files
------------

// File: rtl/load_store_unit.sv
// Load/store unit: word-organised DMEM plus memory-mapped LED/HEX registers and a synchronised switch port.
// Loads are combinational (zero latency); stores commit on the rising edge and cannot stall.
module load_store_unit #(
  parameter int DMEM_BYTES     = 2048,
  parameter int SW_SYNC_STAGES = 2
) (
  input  logic        i_clk,
  input  logic        i_reset,
  input  logic [31:0] i_lsu_addr,
  input  logic [31:0] i_st_data,
  input  logic        i_lsu_wren,
  input  logic [2:0]  i_funct3,
  input  logic [31:0] i_io_sw,
  output logic [31:0] o_ld_data,
  output logic        o_misalign,
  output logic [31:0] o_io_ledr,
  output logic [31:0] o_io_ledg,
  output logic [31:0] o_io_hex_lo,
  output logic [31:0] o_io_hex_hi
);

  localparam int AW    = $clog2(DMEM_BYTES);
  localparam int DEPTH = DMEM_BYTES / 4;

  logic [31:0] dmem_q [DEPTH];
  logic [31:0] ledr_q, ledr_d, ledg_q, ledg_d;
  logic [31:0] hex_lo_q, hex_lo_d, hex_hi_q, hex_hi_d;
  logic [31:0] sw_sync_q [SW_SYNC_STAGES];

  logic [1:0]    ofs;
  logic [AW-3:0] dmem_idx;
  logic          sel_dmem, sel_ledr, sel_ledg, sel_hex_lo, sel_hex_hi, sel_sw;
  logic          is_half, is_word, bad_st, bad_ld, wr_ok;
  logic [3:0]    byte_en;
  logic [31:0]   st_word, bit_mask, rd_word, ld_ext;
  logic [7:0]    rd_byte;
  logic [15:0]   rd_half;

  assign ofs      = i_lsu_addr[1:0];
  assign dmem_idx = i_lsu_addr[AW-1:2];

  // IO registers decode only addr[31:12]; the low 12 bits just pick lanes, so each register mirrors over 4 KiB.
  assign sel_dmem   = (i_lsu_addr[31:AW] == '0);
  assign sel_ledr   = (i_lsu_addr[31:12] == 20'h10000);
  assign sel_ledg   = (i_lsu_addr[31:12] == 20'h10001);
  assign sel_hex_lo = (i_lsu_addr[31:12] == 20'h10002);
  assign sel_hex_hi = (i_lsu_addr[31:12] == 20'h10003);
  assign sel_sw     = (i_lsu_addr[31:12] == 20'h10010);

  assign is_half    = (i_funct3[1:0] == 2'b01);
  assign is_word    = (i_funct3[1:0] == 2'b10);
  assign bad_st     = i_lsu_wren & (i_funct3[2] | (i_funct3 == 3'b011));
  assign bad_ld     = ~i_lsu_wren & ((i_funct3 == 3'b011) | (i_funct3 == 3'b110) | (i_funct3 == 3'b111));
  assign o_misalign = (is_half & ofs[0]) | (is_word & (ofs != 2'b00)) | bad_st | bad_ld;

  assign wr_ok = i_lsu_wren & ~o_misalign & ~i_reset;

  // Replicating the low data bits across the word lands them in whichever lanes byte_en selects.
  always_comb begin
    byte_en = 4'b0000;
    st_word = i_st_data;
    case (i_funct3[1:0])
      2'b00: begin
        byte_en = 4'b0001 << ofs;
        st_word = {4{i_st_data[7:0]}};
      end
      2'b01: begin
        byte_en = ofs[1] ? 4'b1100 : 4'b0011;
        st_word = {2{i_st_data[15:0]}};
      end
      2'b10:   byte_en = 4'b1111;
      default: byte_en = 4'b0000;
    endcase
  end

  assign bit_mask = {{8{byte_en[3]}}, {8{byte_en[2]}}, {8{byte_en[1]}}, {8{byte_en[0]}}};

  assign ledr_d   = (wr_ok & sel_ledr)   ? ((ledr_q   & ~bit_mask) | (st_word & bit_mask)) : ledr_q;
  assign ledg_d   = (wr_ok & sel_ledg)   ? ((ledg_q   & ~bit_mask) | (st_word & bit_mask)) : ledg_q;
  assign hex_lo_d = (wr_ok & sel_hex_lo) ? ((hex_lo_q & ~bit_mask) | (st_word & bit_mask)) : hex_lo_q;
  assign hex_hi_d = (wr_ok & sel_hex_hi) ? ((hex_hi_q & ~bit_mask) | (st_word & bit_mask)) : hex_hi_q;

  always_comb begin
    rd_word = '0;
    if (sel_dmem)        rd_word = dmem_q[dmem_idx];
    else if (sel_ledr)   rd_word = ledr_q;
    else if (sel_ledg)   rd_word = ledg_q;
    else if (sel_hex_lo) rd_word = hex_lo_q;
    else if (sel_hex_hi) rd_word = hex_hi_q;
    else if (sel_sw)     rd_word = sw_sync_q[SW_SYNC_STAGES-1];
  end

  assign rd_byte = rd_word[{ofs, 3'b000} +: 8];
  assign rd_half = ofs[1] ? rd_word[31:16] : rd_word[15:0];

  always_comb begin
    ld_ext = '0;
    case (i_funct3)
      3'b000:  ld_ext = {{24{rd_byte[7]}}, rd_byte};
      3'b001:  ld_ext = {{16{rd_half[15]}}, rd_half};
      3'b010:  ld_ext = rd_word;
      3'b100:  ld_ext = {24'h000000, rd_byte};
      3'b101:  ld_ext = {16'h0000, rd_half};
      default: ld_ext = '0;
    endcase
  end

  assign o_ld_data = o_misalign ? 32'h0000_0000 : ld_ext;

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      ledr_q   <= '0;
      ledg_q   <= '0;
      hex_lo_q <= '0;
      hex_hi_q <= '0;
    end else begin
      ledr_q   <= ledr_d;
      ledg_q   <= ledg_d;
      hex_lo_q <= hex_lo_d;
      hex_hi_q <= hex_hi_d;
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      for (int s = 0; s < SW_SYNC_STAGES; s++) sw_sync_q[s] <= '0;
    end else begin
      sw_sync_q[0] <= i_io_sw;
      for (int s = 1; s < SW_SYNC_STAGES; s++) sw_sync_q[s] <= sw_sync_q[s-1];
    end
  end

  // DMEM deliberately has no reset so its contents survive a core reset.
  always_ff @(posedge i_clk) begin
    if (wr_ok && sel_dmem) begin
      for (int b = 0; b < 4; b++) begin
        if (byte_en[b]) dmem_q[dmem_idx][8*b +: 8] <= st_word[8*b +: 8];
      end
    end
  end

  assign o_io_ledr   = ledr_q;
  assign o_io_ledg   = ledg_q;
  assign o_io_hex_lo = hex_lo_q;
  assign o_io_hex_hi = hex_hi_q;

endmodule

// File: tb/tb_load_store_unit.sv
// Bench for load_store_unit: directed vector table, reset/synchronizer sequences, and random traffic
// checked against a byte-addressed reference model.
module tb_load_store_unit;

  localparam int DMEM_BYTES     = 2048;
  localparam int SW_SYNC_STAGES = 2;
  localparam int AW             = $clog2(DMEM_BYTES);

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] addr, st_data, io_sw;
  logic        wren;
  logic [2:0]  funct3;
  logic [31:0] ld_data, ledr, ledg, hex_lo, hex_hi;
  logic        misalign;

  always #5 clk = ~clk;

  load_store_unit #(.DMEM_BYTES(DMEM_BYTES), .SW_SYNC_STAGES(SW_SYNC_STAGES)) dut (
    .i_clk(clk), .i_reset(rst), .i_lsu_addr(addr), .i_st_data(st_data),
    .i_lsu_wren(wren), .i_funct3(funct3), .i_io_sw(io_sw),
    .o_ld_data(ld_data), .o_misalign(misalign),
    .o_io_ledr(ledr), .o_io_ledg(ledg), .o_io_hex_lo(hex_lo), .o_io_hex_hi(hex_hi)
  );

  int n_chk  = 0;
  int n_pass = 0;

  // Reference model: memory as individual bytes, IO registers as byte lanes, synchronizer as a delay queue.
  logic [7:0]  dm   [DMEM_BYTES];
  logic [7:0]  io_b [4][4];
  logic [31:0] sw_hist [$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  function automatic int region(input logic [31:0] a);
    if (a < 32'(DMEM_BYTES)) return 0;
    if (a[31:12] >= 20'h10000 && a[31:12] <= 20'h10003) return 1 + int'(a[13:12]);
    if (a[31:12] == 20'h10010) return 5;
    return 6;
  endfunction

  function automatic logic [7:0] byte_rd(input logic [31:0] a);
    logic [31:0] t;
    case (region(a))
      0: return dm[a[AW-1:0]];
      1, 2, 3, 4: return io_b[region(a)-1][a[1:0]];
      5: begin
        t = sw_hist[0] >> (8 * int'(a[1:0]));
        return t[7:0];
      end
      default: return 8'h00;
    endcase
  endfunction

  function automatic void byte_wr(input logic [31:0] a, input logic [7:0] b);
    case (region(a))
      0: dm[a[AW-1:0]] = b;
      1, 2, 3, 4: io_b[region(a)-1][a[1:0]] = b;
      default: ;
    endcase
  endfunction

  function automatic int acc_size(input logic [2:0] f);
    return (f[1:0] == 2'b00) ? 1 : (f[1:0] == 2'b01) ? 2 : 4;
  endfunction

  function automatic logic [31:0] io_word(input int r);
    return {io_b[r][3], io_b[r][2], io_b[r][1], io_b[r][0]};
  endfunction

  task automatic model_eval(input logic [31:0] a, input logic we, input logic [2:0] f,
                            output logic mis, output logic [31:0] ld);
    int size;
    bit legal;
    logic [31:0] v;
    size  = acc_size(f);
    legal = we ? (f <= 3'd2) : (f inside {3'd0, 3'd1, 3'd2, 3'd4, 3'd5});
    mis   = !legal || ((int'(a[1:0]) % size) != 0);
    v = 32'h0;
    for (int k = 0; k < size; k++) v = v | (32'(byte_rd(a + 32'(k))) << (8 * k));
    if (!f[2] && size == 1) v = {{24{v[7]}}, v[7:0]};
    if (!f[2] && size == 2) v = {{16{v[15]}}, v[15:0]};
    ld = mis ? 32'h0 : v;
  endtask

  task automatic model_commit(input logic [31:0] a, d, input logic we, input logic [2:0] f,
                              input logic r, input logic [31:0] sw);
    logic mis;
    logic [31:0] unused_ld;
    model_eval(a, we, f, mis, unused_ld);
    if (r) begin
      for (int i = 0; i < 4; i++) for (int j = 0; j < 4; j++) io_b[i][j] = 8'h00;
      sw_hist.delete();
      for (int s = 0; s < SW_SYNC_STAGES; s++) sw_hist.push_back(32'h0);
    end else begin
      if (we && !mis) for (int k = 0; k < acc_size(f); k++) byte_wr(a + 32'(k), d[8*k +: 8]);
      sw_hist.push_back(sw);
      void'(sw_hist.pop_front());
    end
  endtask

  // One clock cycle: drive at the falling edge, sample 1 ns later, then let the rising edge commit.
  task automatic cycle(input logic [31:0] a, d, input logic we, input logic [2:0] f,
                       input logic r, input logic [31:0] sw, input bit mchk,
                       output logic mis_o, output logic [31:0] ld_o);
    logic emis;
    logic [31:0] eld;
    addr = a; st_data = d; wren = we; funct3 = f; rst = r; io_sw = sw;
    #1;
    mis_o = misalign;
    ld_o  = ld_data;
    if (mchk) begin
      model_eval(a, we, f, emis, eld);
      chk("model_misalign", 32'(misalign), 32'(emis));
      chk("model_ld_data", ld_data, eld);
      chk("model_ledr", ledr, io_word(0));
      chk("model_ledg", ledg, io_word(1));
      chk("model_hex_lo", hex_lo, io_word(2));
      chk("model_hex_hi", hex_hi, io_word(3));
    end
    @(posedge clk);
    model_commit(a, d, we, f, r, sw);
    @(negedge clk);
  endtask

  typedef struct packed {
    logic [31:0] a;
    logic [31:0] d;
    logic        we;
    logic [2:0]  f;
    logic [31:0] ld;
    logic        mis;
  } vec_t;

  vec_t tbl [$];

  initial begin
    logic        m;
    logic [31:0] l, a, d;
    logic [2:0]  f;
    logic        we, r;
    logic [31:0] sw;
    int          sel, size;

    addr = '0; st_data = '0; wren = 1'b0; funct3 = 3'd2; rst = 1'b1; io_sw = '0;
    for (int s = 0; s < SW_SYNC_STAGES; s++) sw_hist.push_back(32'h0);
    @(negedge clk);

    for (int i = 0; i < 3; i++) cycle(32'h0, 32'h0, 1'b0, 3'd2, 1'b1, 32'h0, 1'b0, m, l);
    chk("rst_ledr", ledr, 32'h0);
    chk("rst_ledg", ledg, 32'h0);
    chk("rst_hex_lo", hex_lo, 32'h0);
    chk("rst_hex_hi", hex_hi, 32'h0);
    cycle(32'h1001_0000, 32'h0, 1'b0, 3'd2, 1'b0, 32'h0, 1'b1, m, l);
    chk("rst_sw_sync", l, 32'h0);

    for (int i = 0; i < DMEM_BYTES / 4; i++)
      cycle(32'(4 * i), {16'hC0DE, 16'(i)}, 1'b1, 3'd2, 1'b0, 32'h0, 1'b0, m, l);

    //                a             d             we    f     expected ld   mis
    tbl.push_back('{32'h0000_0010, 32'hDEADBEEF, 1'b1, 3'd2, 32'hC0DE0004, 1'b0});
    tbl.push_back('{32'h0000_0013, 32'h0,        1'b0, 3'd0, 32'hFFFFFFDE, 1'b0});
    tbl.push_back('{32'h0000_0013, 32'h0,        1'b0, 3'd4, 32'h000000DE, 1'b0});
    tbl.push_back('{32'h0000_0012, 32'h0,        1'b0, 3'd1, 32'hFFFFDEAD, 1'b0});
    tbl.push_back('{32'h0000_0010, 32'h0,        1'b0, 3'd5, 32'h0000BEEF, 1'b0});
    tbl.push_back('{32'h0000_0020, 32'h11223344, 1'b1, 3'd2, 32'hC0DE0008, 1'b0});
    tbl.push_back('{32'h0000_0021, 32'hFFFFFFAA, 1'b1, 3'd0, 32'h00000033, 1'b0});
    tbl.push_back('{32'h0000_0022, 32'h12345566, 1'b1, 3'd1, 32'h00001122, 1'b0});
    tbl.push_back('{32'h0000_0020, 32'h0,        1'b0, 3'd2, 32'h5566AA44, 1'b0});
    tbl.push_back('{32'h0000_0006, 32'hCAFEF00D, 1'b1, 3'd2, 32'h00000000, 1'b1});
    tbl.push_back('{32'h0000_0003, 32'h0,        1'b0, 3'd1, 32'h00000000, 1'b1});
    tbl.push_back('{32'h0000_0004, 32'h0,        1'b0, 3'd2, 32'hC0DE0001, 1'b0});
    tbl.push_back('{32'h2000_0000, 32'h0,        1'b0, 3'd2, 32'h00000000, 1'b0});
    tbl.push_back('{32'h2000_0000, 32'h12345678, 1'b1, 3'd2, 32'h00000000, 1'b0});
    tbl.push_back('{32'h0000_0000, 32'h0,        1'b0, 3'd2, 32'hC0DE0000, 1'b0});
    tbl.push_back('{32'h0000_0000, 32'h0,        1'b0, 3'd3, 32'h00000000, 1'b1});
    tbl.push_back('{32'h0000_0024, 32'h77777777, 1'b1, 3'd4, 32'h00000000, 1'b1});
    tbl.push_back('{32'h0000_0024, 32'h0,        1'b0, 3'd2, 32'hC0DE0009, 1'b0});
    tbl.push_back('{32'h0000_0000, 32'h0,        1'b0, 3'd6, 32'h00000000, 1'b1});
    tbl.push_back('{32'h0000_0027, 32'h0,        1'b0, 3'd4, 32'h000000C0, 1'b0});

    foreach (tbl[i]) begin
      cycle(tbl[i].a, tbl[i].d, tbl[i].we, tbl[i].f, 1'b0, 32'h0, 1'b1, m, l);
      chk($sformatf("vec%0d_ld", i), l, tbl[i].ld);
      chk($sformatf("vec%0d_mis", i), 32'(m), 32'(tbl[i].mis));
    end

    // LED writes, then a reset edge that also carries a store which must be dropped.
    cycle(32'h1000_0000, 32'h0000_00FF, 1'b1, 3'd2, 1'b0, 32'h0, 1'b1, m, l);
    cycle(32'h1000_1002, 32'h0000_000F, 1'b1, 3'd0, 1'b0, 32'h0, 1'b1, m, l);
    cycle(32'h1000_0000, 32'h0, 1'b0, 3'd2, 1'b0, 32'h0, 1'b1, m, l);
    chk("ledr_load_before_rst", l, 32'h0000_00FF);
    cycle(32'h1000_1000, 32'h0, 1'b0, 3'd2, 1'b1, 32'h0, 1'b1, m, l);
    chk("ledg_load_during_rst", l, 32'h000F_0000);
    cycle(32'h1000_2000, 32'h0000_1234, 1'b1, 3'd2, 1'b1, 32'h0, 1'b1, m, l);
    chk("hex_lo_store_in_rst", hex_lo, 32'h0);
    cycle(32'h1000_0004, 32'h0, 1'b0, 3'd2, 1'b0, 32'h0, 1'b1, m, l);
    chk("ledr_load_after_rst", l, 32'h0);
    cycle(32'h1000_1FFC, 32'h0, 1'b0, 3'd2, 1'b0, 32'h0, 1'b1, m, l);
    chk("ledg_load_after_rst", l, 32'h0);
    chk("ledr_out_after_rst", ledr, 32'h0);

    // Switch synchronizer latency, then a store to the read-only switch port.
    for (int k = 0; k <= SW_SYNC_STAGES; k++) begin
      cycle(32'h1001_0000, 32'h0, 1'b0, 3'd2, 1'b0, 32'h155, 1'b1, m, l);
      chk($sformatf("sw_sync_edge%0d", k), l, (k >= SW_SYNC_STAGES) ? 32'h155 : 32'h0);
    end
    cycle(32'h1001_0000, 32'h0, 1'b1, 3'd2, 1'b0, 32'h155, 1'b1, m, l);
    cycle(32'h1001_0000, 32'h0, 1'b0, 3'd2, 1'b0, 32'h155, 1'b1, m, l);
    chk("sw_store_ignored", l, 32'h155);
    cycle(32'h1001_0001, 32'h0, 1'b0, 3'd4, 1'b0, 32'h155, 1'b1, m, l);
    chk("sw_lbu_lane1", l, 32'h01);

    sw = 32'h155;
    for (int n = 0; n < 2000; n++) begin
      f    = 3'($urandom_range(0, 7));
      we   = 1'($urandom_range(0, 1));
      r    = ($urandom_range(0, 49) == 0);
      d    = $urandom;
      sel  = $urandom_range(0, 9);
      size = acc_size(f);
      if (sel < 5)       a = 32'($urandom_range(0, DMEM_BYTES - 1));
      else if (sel < 8)  a = 32'h1000_0000 + (32'($urandom_range(0, 3)) << 12) + 32'($urandom_range(0, 4095));
      else if (sel == 8) a = 32'h1001_0000 + 32'($urandom_range(0, 4095));
      else               a = $urandom;
      if ($urandom_range(0, 9) < 7) a = a & ~32'(size - 1);
      if ($urandom_range(0, 9) < 3) sw = $urandom;
      cycle(a, d, we, f, r, sw, 1'b1, m, l);
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
